// File: rtl/rsa_stage_ctrl.sv
// RSA stage sequencer: accepts one EKF stage, takes a nonlinear token, computes, returns a result.
// Optional RSA_HANDSHAKE_TIMEOUT_EN aborts a stage after 255 idle handshake cycles.
module rsa_stage_ctrl #(
  parameter int X            = 4,
  parameter int Y            = 4,
  parameter int L            = 4,
  parameter int RSA_DW       = 16,
  parameter int TB_AW        = 12,
  parameter int CB_AW        = 19,
  parameter int MAX_LANDMARK = 500,
  parameter int ROW_LEN      = 10
) (
  input  logic       clk,
  input  logic       sys_rst,
  input  logic [2:0] stage_val,
  output logic [2:0] stage_rdy,
  input  logic [2:0] nonlinear_s_val,
  output logic [2:0] nonlinear_m_rdy,
  output logic [2:0] nonlinear_m_val,
  input  logic [2:0] nonlinear_s_rdy
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WAIT_IN,
    S_COMPUTE,
    S_WAIT_OUT,
    S_DONE
  } state_t;

  localparam int CW = $clog2(X + Y + L + 1);
  localparam logic [CW-1:0] C0 = CW'(L - 1);
  localparam logic [CW-1:0] C1 = CW'(X + L - 1);
  localparam logic [CW-1:0] C2 = CW'(X + Y + L - 1);
  localparam int CFG_SUM = RSA_DW + TB_AW + CB_AW + MAX_LANDMARK + ROW_LEN;

  // Datapath parameters only pass through this block.
  logic w_unused_cfg;
  assign w_unused_cfg = CFG_SUM[0];

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_sel, w_sel_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [2:0]      w_sel_oh;
  logic            w_in_hs, w_out_hs;
  logic [CW-1:0]   w_cyc_m1;
  logic            w_wait_exp;

  assign w_sel_oh = 3'b001 << r_sel;
  assign w_in_hs  = |(nonlinear_s_val & w_sel_oh);
  assign w_out_hs = |(nonlinear_s_rdy & w_sel_oh);

  always_comb begin
    w_cyc_m1 = C0;
    case (r_sel)
      2'd1:    w_cyc_m1 = C1;
      2'd2:    w_cyc_m1 = C2;
      default: w_cyc_m1 = C0;
    endcase
  end

`ifdef RSA_HANDSHAKE_TIMEOUT_EN
  logic [7:0] r_wcnt;

  assign w_wait_exp = (r_wcnt == 8'd254);

  always_ff @(posedge clk) begin
    if (sys_rst)
      r_wcnt <= 8'd0;
    else if (w_state_nxt != r_state)
      r_wcnt <= 8'd0;
    else if (r_state == S_WAIT_IN || r_state == S_WAIT_OUT)
      r_wcnt <= r_wcnt + 8'd1;
  end
`else
  assign w_wait_exp = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state <= S_INIT;
      r_sel   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_sel_nxt       = r_sel;
    w_cnt_nxt       = r_cnt;
    stage_rdy       = 3'b000;
    nonlinear_m_rdy = 3'b000;
    nonlinear_m_val = 3'b000;
    case (r_state)
      S_INIT: w_state_nxt = S_IDLE;
      S_IDLE: begin
        stage_rdy = 3'b111;
        // Lowest requested stage wins; others are dropped.
        if (stage_val[0]) begin
          w_sel_nxt   = 2'd0;
          w_state_nxt = S_WAIT_IN;
        end else if (stage_val[1]) begin
          w_sel_nxt   = 2'd1;
          w_state_nxt = S_WAIT_IN;
        end else if (stage_val[2]) begin
          w_sel_nxt   = 2'd2;
          w_state_nxt = S_WAIT_IN;
        end
      end
      S_WAIT_IN: begin
        nonlinear_m_rdy = w_sel_oh;
        if (w_in_hs) begin
          w_state_nxt = S_COMPUTE;
          w_cnt_nxt   = w_cyc_m1;
        end else if (w_wait_exp) begin
          w_state_nxt = S_DONE;
        end
      end
      S_COMPUTE: begin
        if (r_cnt == '0)
          w_state_nxt = S_WAIT_OUT;
        else
          w_cnt_nxt = r_cnt - 1'b1;
      end
      S_WAIT_OUT: begin
        nonlinear_m_val = w_sel_oh;
        if (w_out_hs || w_wait_exp)
          w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_rsa_stage_ctrl.sv
// Self-checking bench for rsa_stage_ctrl: transaction timeline model
// (lowest-bit select, fixed compute length per stage) with random delays and noise.
module tb_rsa_stage_ctrl;

  localparam int X = 4;
  localparam int Y = 4;
  localparam int L = 4;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic [2:0] stage_val;
  logic [2:0] stage_rdy;
  logic [2:0] nonlinear_s_val;
  logic [2:0] nonlinear_m_rdy;
  logic [2:0] nonlinear_m_val;
  logic [2:0] nonlinear_s_rdy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rsa_stage_ctrl #(.X(X), .Y(Y), .L(L)) dut (
    .clk             (clk),
    .sys_rst         (sys_rst),
    .stage_val       (stage_val),
    .stage_rdy       (stage_rdy),
    .nonlinear_s_val (nonlinear_s_val),
    .nonlinear_m_rdy (nonlinear_m_rdy),
    .nonlinear_m_val (nonlinear_m_val),
    .nonlinear_s_rdy (nonlinear_s_rdy)
  );

  function automatic logic [8:0] obs();
    return {stage_rdy, nonlinear_m_rdy, nonlinear_m_val};
  endfunction

  function automatic int low_idx(input logic [2:0] r);
    for (int i = 0; i < 3; i++)
      if (r[i]) return i;
    return 0;
  endfunction

  function automatic int cyc_of(input int s);
    int tab [3];
    tab[0] = L;
    tab[1] = X + L;
    tab[2] = X + Y + L;
    return tab[s];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expects IDLE on entry; leaves the DUT in IDLE.
  task automatic run_stage(input string nm, input logic [2:0] req,
                           input int din, input int dout,
                           input bit hold, input bit noise);
    logic [2:0] oh;
    logic [8:0] e;
    int cyc;
    oh  = 3'b001 << low_idx(req);
    cyc = cyc_of(low_idx(req));
    e = {3'b111, 6'b0};
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL %s idle: got %b exp %b", nm, obs(), e);
    end
    stage_val = req;
    nonlinear_s_val = 3'b000;
    nonlinear_s_rdy = 3'b000;
    step();
    stage_val = hold ? req : 3'b000;
    for (int i = 0; i < din; i++) begin
      e = {3'b000, oh, 3'b000};
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL %s wait_in %0d: got %b exp %b", nm, i, obs(), e);
      end
      nonlinear_s_val = noise ? (3'($urandom) & ~oh) : 3'b000;
      nonlinear_s_rdy = noise ? 3'($urandom) : 3'b000;
      step();
      stage_val = 3'b000;
    end
    e = {3'b000, oh, 3'b000};
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL %s wait_in_last: got %b exp %b", nm, obs(), e);
    end
    nonlinear_s_val = oh;
    nonlinear_s_rdy = 3'b000;
    step();
    stage_val = 3'b000;
    for (int c = 0; c < cyc; c++) begin
      e = 9'b0;
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL %s compute %0d/%0d: got %b exp %b", nm, c, cyc, obs(), e);
      end
      nonlinear_s_val = noise ? 3'($urandom) : 3'b000;
      nonlinear_s_rdy = noise ? 3'($urandom) : 3'b000;
      step();
    end
    for (int i = 0; i < dout; i++) begin
      e = {6'b0, oh};
      n_vec++;
      if (obs() !== e) begin
        n_err++;
        $display("FAIL %s wait_out %0d: got %b exp %b", nm, i, obs(), e);
      end
      nonlinear_s_val = noise ? 3'($urandom) : 3'b000;
      nonlinear_s_rdy = noise ? (3'($urandom) & ~oh) : 3'b000;
      step();
    end
    e = {6'b0, oh};
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL %s wait_out_last: got %b exp %b", nm, obs(), e);
    end
    nonlinear_s_val = 3'b000;
    nonlinear_s_rdy = oh;
    step();
    nonlinear_s_rdy = 3'b000;
    e = 9'b0;
    n_vec++;
    if (obs() !== e) begin
      n_err++;
      $display("FAIL %s done: got %b exp %b", nm, obs(), e);
    end
    step();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    stage_val = 3'b000;
    nonlinear_s_val = 3'b000;
    nonlinear_s_rdy = 3'b000;
    for (int i = 0; i < 2; i++) begin
      step();
      n_vec++;
      if (obs() !== 9'b0) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %b exp %b", i, obs(), 9'b0);
      end
    end
    sys_rst = 1'b0;
    n_vec++;
    if (obs() !== 9'b0) begin
      n_err++;
      $display("FAIL reset init: got %b exp %b", obs(), 9'b0);
    end
    step();
    n_vec++;
    if (obs() !== {3'b111, 6'b0}) begin
      n_err++;
      $display("FAIL reset idle: got %b exp %b", obs(), {3'b111, 6'b0});
    end
  endtask

  task automatic test_reset_mid();
    stage_val = 3'b100;
    step();
    stage_val = 3'b000;
    nonlinear_s_val = 3'b100;
    step();
    nonlinear_s_val = 3'b000;
    step();
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    n_vec++;
    if (obs() !== 9'b0) begin
      n_err++;
      $display("FAIL reset_mid abort: got %b exp %b", obs(), 9'b0);
    end
    step();
    run_stage("reset_mid_after", 3'b010, 1, 1, 1'b0, 1'b0);
  endtask

`ifdef RSA_HANDSHAKE_TIMEOUT_EN
  task automatic test_timeout();
    stage_val = 3'b001;
    step();
    stage_val = 3'b000;
    for (int i = 0; i < 255; i++) begin
      n_vec++;
      if (obs() !== 9'b000_001_000) begin
        n_err++;
        $display("FAIL timeout wait %0d: got %b exp %b", i, obs(), 9'b000_001_000);
      end
      step();
    end
    n_vec++;
    if (obs() !== 9'b0) begin
      n_err++;
      $display("FAIL timeout done: got %b exp %b", obs(), 9'b0);
    end
    step();
    n_vec++;
    if (obs() !== {3'b111, 6'b0}) begin
      n_err++;
      $display("FAIL timeout idle: got %b exp %b", obs(), {3'b111, 6'b0});
    end
  endtask
`endif

  initial begin
    test_reset();
    repeat (3) step();
    run_stage("stage0_seq", 3'b001, 4, 0, 1'b1, 1'b0);
    run_stage("stage1_pri", 3'b110, 2, 3, 1'b0, 1'b0);
    run_stage("stage2_stall", 3'b100, 1, 50, 1'b0, 1'b0);
    run_stage("wrong_bits", 3'b001, 5, 4, 1'b0, 1'b1);
    for (int k = 0; k < 25; k++)
      run_stage("random", 3'($urandom_range(1, 7)),
                int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                1'($urandom), 1'b1);
    test_reset_mid();
`ifdef RSA_HANDSHAKE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rsa_stage_ctrl.md
Name: rsa_stage_ctrl

Overview:
- Stage sequencer / handshake controller of the reconfigurable systolic array (RSA) in the EKF-SLAM accelerator.
- Accepts one of three EKF stage requests: bit0 = predict, bit1 = new-landmark, bit2 = update.
- For the accepted stage: takes one input token from the nonlinear unit, runs a fixed-length compute phase, then hands one result token back to the nonlinear unit.
- Datapath parameters are carried so the block drops into the full RSA hierarchy unchanged.

Parameters:
X, 4, PE array rows; sets compute length
Y, 4, PE array columns; sets compute length
L, 4, PE pipeline depth; sets compute length
RSA_DW, 16, datapath word width; accepted, unused here
TB_AW, 12, temp-buffer address width; accepted, unused here
CB_AW, 19, covariance-buffer address width; accepted, unused here
MAX_LANDMARK, 500, maximum landmark count; accepted, unused here
ROW_LEN, 10, buffer row length; accepted, unused here

Ports:
clk  in  1  clock, all logic on rising edge
sys_rst  in  1  synchronous active-high reset
stage_val  in  3  one-hot stage request from the top-level scheduler
stage_rdy  out  3  controller idle, per stage bit
nonlinear_s_val  in  3  nonlinear unit presents an input token for stage i
nonlinear_m_rdy  out  3  RSA ready to take a nonlinear input for stage i
nonlinear_m_val  out  3  RSA result valid toward the nonlinear unit for stage i
nonlinear_s_rdy  in  3  nonlinear unit accepts the RSA result for stage i

Behaviour:
- All outputs are Moore-decoded from registered state plus a registered 2-bit stage index `sel`.
- States: INIT, IDLE, WAIT_IN, COMPUTE, WAIT_OUT, DONE.
- Reset (sys_rst=1 at a clock edge):
  - state goes to INIT; sel=0; compute counter=0.
  - All outputs are 0 during reset and in INIT.
  - Reset mid-operation aborts any stage immediately; no handshake completes.
- INIT: proceeds to IDLE on the next edge unconditionally.
- IDLE:
  - stage_rdy=3'b111; all other outputs are 0.
  - A stage is accepted at an edge where stage_val!=0.
  - If more than one bit is set, the lowest set index wins; the other requests are dropped, not queued.
  - On accept: sel=index and state goes to WAIT_IN.
- WAIT_IN:
  - stage_rdy=0; nonlinear_m_rdy is one-hot at bit sel.
  - Handshake completes when nonlinear_s_val[sel]=1 at an edge; then state goes to COMPUTE and the counter loads CYC-1.
  - nonlinear_s_val on the other bits is ignored.
- COMPUTE:
  - All outputs are 0. Counter decrements each cycle; leave for WAIT_OUT when counter==0.
  - Duration is exactly CYC cycles: CYC = L for stage0, X+L for stage1, X+Y+L for stage2. Defaults give 4, 8, 12.
  - The counter must be wide enough for X+Y+L.
- WAIT_OUT:
  - nonlinear_m_val is one-hot at bit sel and is held until nonlinear_s_rdy[sel]=1 at an edge; then state goes to DONE.
  - val must not drop before the handshake.
- DONE: all outputs are 0 for one cycle; then state goes to IDLE.
- stage_val is ignored outside IDLE. A request held high across the accept edge is not re-accepted until IDLE is reached again.
- Simultaneous events:
  - s_val arriving while not in WAIT_IN is lost; a sender must hold it.
  - s_rdy arriving before WAIT_OUT has no effect.
- No X is ever propagated on outputs after the first reset.

Optional Feature:
- Macro RSA_HANDSHAKE_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter runs in WAIT_IN and WAIT_OUT and clears on each state entry.
  - If 255 cycles elapse without the handshake, the FSM goes to DONE, then IDLE, aborting the stage.
  - The abort does not assert nonlinear_m_val in WAIT_IN.
- When undefined: the FSM waits indefinitely; no counter logic is synthesized.

Test Plan:
1. Reset held for 2 cycles.
   - Required: all outputs are 0 during reset and in INIT; stage_rdy=3'b111 from the second cycle after release.
2. Stage0 handshake sequence:
   - stage_val=3'b001 for 2 cycles at cycle 20 → accepted at 20; nonlinear_m_rdy=3'b001 from 21.
   - nonlinear_s_val=001 at cycles 25-26 → taken at 25; outputs 0 during cycles 26-29.
   - nonlinear_m_val=001 at 30; nonlinear_s_rdy=001 at 30-31 → DONE at 31; stage_rdy=111 at 32.
3. stage_val=3'b110 in IDLE → stage1 selected; COMPUTE lasts 8 cycles; nonlinear_m_rdy and nonlinear_m_val appear only on bit1.
4. Stage2 with nonlinear_s_rdy withheld 50 cycles → nonlinear_m_val=100 held steady all 50 cycles; completes one cycle after s_rdy; COMPUTE was 12 cycles.
5. Wrong-bit and early signals:
   - nonlinear_s_val=010 during a stage0 WAIT_IN → ignored.
   - nonlinear_s_rdy pulsed during COMPUTE → ignored; the FSM still stalls in WAIT_OUT.
6. sys_rst asserted during COMPUTE → all outputs 0 next cycle; a new stage is accepted normally afterward.
   - With RSA_HANDSHAKE_TIMEOUT_EN: no s_val for 255 cycles → FSM returns to IDLE.
